fetch_ctrl: RTL

Sequences the fetch stage against a variable-latency instruction memory using a request/grant/response handshake. Owns the fetch PC, sequential PC increment and branch redirect (PCSrc_F/PCBranch_F), and the hand-off of a fetched instruction plus its PC to decode under a decode stall. Sits between the branch-resolution logic, the imem port and the F/D pipeline register.

---
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer over a req/gnt/rvalid instruction memory port.
// Ports: clk, reset (async, active-high); PCSrc_F/PCBranch_F redirect in;
// imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in; stall_D in;
// inst_valid_D/inst_D/pc_D hand-off to decode.
// Optional FETCH_TIMEOUT_EN: adds TIMEOUT_CYCLES parameter, sticky imem_timeout
// output and an S_WAIT watchdog that re-requests the current PC.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter logic [63:0] PC_STEP  = 64'd4
`ifdef FETCH_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc_F,
    input  logic [63:0] PCBranch_F,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_D,
    output logic        inst_valid_D,
    output logic [31:0] inst_D,
    output logic [63:0] pc_D
`ifdef FETCH_TIMEOUT_EN
    , output logic      imem_timeout
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d, pc_dec_q, pc_dec_d;
    logic [31:0] inst_q, inst_d;
    logic        kill_q, kill_d, valid_q, valid_d;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`endif
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_dec_d = pc_dec_q;
        inst_d   = inst_q;
        kill_d   = kill_q;
        valid_d  = valid_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = to_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    // a redirect coinciding with the grant makes this request stale
                    state_d = S_WAIT;
                    kill_d  = PCSrc_F;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || PCSrc_F) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d   = imem_rdata;
                        pc_dec_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                    end
                end else begin
                    kill_d = kill_q | PCSrc_F;
`ifdef FETCH_TIMEOUT_EN
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        to_d    = 1'b1;
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (PCSrc_F || !stall_D) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // redirect overrides any sequential increment, in every state
        if (PCSrc_F) pc_d = PCBranch_F;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            pc_dec_q <= 64'd0;
            inst_q   <= 32'd0;
            kill_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_dec_q <= pc_dec_d;
            inst_q   <= inst_d;
            kill_q   <= kill_d;
            valid_q  <= valid_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= cnt_d;
            to_q     <= to_d;
`endif
        end
    end
    assign imem_req     = (state_q == S_REQ);
    assign imem_addr    = pc_q;
    assign inst_valid_D = valid_q;
    assign inst_D       = inst_q;
    assign pc_D         = pc_dec_q;
`ifdef FETCH_TIMEOUT_EN
    assign imem_timeout = to_q;
`endif
endmodule
